// File: rtl/qpl_pkg.sv
// Shared widths, alloc FSM state encodings and reply field offsets for the QPL
// block dispatcher.
package qpl_pkg;

    localparam logic [2:0] A_IDLE   = 3'd0;
    localparam logic [2:0] A_SELECT = 3'd1;
    localparam logic [2:0] A_ISSUE  = 3'd2;
    localparam logic [2:0] A_WAIT   = 3'd3;
    localparam logic [2:0] A_REPLY  = 3'd4;

    function automatic int req_w(input int udata_w, input int block_d, input int line_byte);
        return udata_w + $clog2(block_d * line_byte) + 1;
    endfunction

    function automatic int rep_w(input int udata_w, input int block_d);
        return udata_w + 2 * $clog2(block_d) + 1;
    endfunction

    function automatic int xrep_w(input int nblk, input int udata_w, input int block_d);
        return $clog2(nblk) + rep_w(udata_w, block_d);
    endfunction

    // Reply layout is {udata, base, size_lines}; size_lines sits at bit 0.
    function automatic int rep_base_lsb(input int block_d);
        return $clog2(block_d) + 1;
    endfunction

    function automatic int rep_udata_lsb(input int block_d);
        return 2 * $clog2(block_d) + 1;
    endfunction

endpackage

// File: rtl/qpl_blk_dispatch_if.sv
// PU-side alloc/dealloc request and reply streams of the QPL block dispatcher.
interface qpl_blk_dispatch_if #(
    parameter int REQ_W  = 18,
    parameter int XREP_W = 17
);
    logic              req_alloc_vld;
    logic              req_alloc_rdy;
    logic [REQ_W-1:0]  req_alloc_data;
    logic              req_dealloc_vld;
    logic              req_dealloc_rdy;
    logic [XREP_W-1:0] req_dealloc_data;
    logic              rep_alloc_vld;
    logic              rep_alloc_rdy;
    logic [XREP_W-1:0] rep_alloc_data;
    logic              rep_dealloc_vld;
    logic              rep_dealloc_rdy;
    logic [XREP_W-1:0] rep_dealloc_data;

    modport master (
        output req_alloc_vld, req_alloc_data, input req_alloc_rdy,
        output req_dealloc_vld, req_dealloc_data, input req_dealloc_rdy,
        input rep_alloc_vld, rep_alloc_data, output rep_alloc_rdy,
        input rep_dealloc_vld, rep_dealloc_data, output rep_dealloc_rdy
    );

    modport slave (
        input req_alloc_vld, req_alloc_data, output req_alloc_rdy,
        input req_dealloc_vld, req_dealloc_data, output req_dealloc_rdy,
        output rep_alloc_vld, rep_alloc_data, input rep_alloc_rdy,
        output rep_dealloc_vld, rep_dealloc_data, input rep_dealloc_rdy
    );
endinterface

// File: rtl/qpl_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping
// modulo N, wins.
module qpl_rr_arb #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan from ptr upward; the first hit locks out later positions.
    always_comb begin
        int j;
        gnt = {N{1'b0}};
        idx = {IW{1'b0}};
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            j = (j >= N) ? j - N : j;
            if (!any && req[IW'(j)]) begin
                any          = 1'b1;
                gnt[IW'(j)]  = 1'b1;
                idx          = IW'(j);
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/qpl_blk_dispatch.sv
// Spreads PU alloc requests over NBLK QPL blocks (occupancy-aware round robin
// with retry) and steers deallocs by block ID, merging block replies back.
module qpl_blk_dispatch
    import qpl_pkg::*;
#(
    parameter int NBLK      = 4,
    parameter int LINE_BYTE = 64,
    parameter int BLOCK_D   = 8,
    parameter int UDATA_W   = 8,
    localparam int BLOCK_W  = $clog2(BLOCK_D),
    localparam int BID_W    = $clog2(NBLK),
    localparam int SZ_W     = $clog2(BLOCK_D * LINE_BYTE) + 1,
    localparam int REQ_W    = req_w(UDATA_W, BLOCK_D, LINE_BYTE),
    localparam int REP_W    = rep_w(UDATA_W, BLOCK_D),
    localparam int XREP_W   = xrep_w(NBLK, UDATA_W, BLOCK_D)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    qpl_blk_dispatch_if.slave   pu,
    output logic [NBLK-1:0]     o_blk_req_alloc_vld,
    output logic [REQ_W-1:0]    o_blk_req_alloc_data,
    input  logic [NBLK-1:0]     i_blk_req_alloc_rdy,
    input  logic [NBLK-1:0]     i_blk_rep_alloc_vld,
    input  logic [REP_W-1:0]    i_blk_rep_alloc_data [NBLK],
    output logic [NBLK-1:0]     o_blk_rep_alloc_rdy,
    output logic [NBLK-1:0]     o_blk_req_dealloc_vld,
    output logic [REP_W-1:0]    o_blk_req_dealloc_data,
    input  logic [NBLK-1:0]     i_blk_req_dealloc_rdy,
    input  logic [NBLK-1:0]     i_blk_rep_dealloc_vld,
    input  logic [REP_W-1:0]    i_blk_rep_dealloc_data [NBLK],
    output logic [NBLK-1:0]     o_blk_rep_dealloc_rdy,
    input  logic [BLOCK_W:0]    i_blk_avail [NBLK],
    output logic [BID_W-1:0]    o_rr_ptr
);

    localparam int LSH = $clog2(LINE_BYTE);
    localparam logic [SZ_W-1:0] LMASK = SZ_W'(LINE_BYTE - 1);
    localparam int BASE_LSB  = rep_base_lsb(BLOCK_D);
    localparam int UDATA_LSB = rep_udata_lsb(BLOCK_D);

    function automatic logic [BID_W-1:0] bid_inc(input logic [BID_W-1:0] b);
        if (b == BID_W'(NBLK - 1)) begin
            return {BID_W{1'b0}};
        end else begin
            return b + BID_W'(1);
        end
    endfunction

    // ---------------- alloc path ----------------
    logic [2:0]        state_r;
    logic              live_r;
    logic [REQ_W-1:0]  req_r;
    logic [SZ_W-1:0]   need_r;
    logic [SZ_W-1:0]   need_s;
    logic [NBLK-1:0]   tried_r;
    logic [NBLK-1:0]   fits_s;
    logic [NBLK-1:0]   cand_gnt_s;
    logic [BID_W-1:0]  cand_r;
    logic [BID_W-1:0]  cand_idx_s;
    logic              cand_any_s;
    logic [BID_W-1:0]  rr_ptr_r;
    logic [XREP_W-1:0] rep_r;
    logic              alloc_rdy_s;
    logic              alloc_hs_s;
    logic [REP_W-1:0]  rep_sel_s;
    logic              rep_vld_s;

    assign alloc_rdy_s = live_r && (state_r == A_IDLE);
    assign alloc_hs_s  = pu.req_alloc_vld && alloc_rdy_s;
    assign need_s      = (pu.req_alloc_data[SZ_W-1:0] >> LSH)
                       + {{(SZ_W-1){1'b0}}, |(pu.req_alloc_data[SZ_W-1:0] & LMASK)};
    assign rep_sel_s   = i_blk_rep_alloc_data[cand_r];
    assign rep_vld_s   = i_blk_rep_alloc_vld[cand_r];

    // Blocks whose sampled free-line count covers the request.
    always_comb begin
        fits_s = {NBLK{1'b0}};
        for (int i = 0; i < NBLK; i++) begin
            fits_s[i] = (SZ_W'(i_blk_avail[i]) >= need_r);
        end
    end

    qpl_rr_arb #(.N(NBLK)) u_alloc_arb (
        .req (~tried_r & fits_s),
        .ptr (rr_ptr_r),
        .gnt (cand_gnt_s),
        .idx (cand_idx_s),
        .any (cand_any_s)
    );

    // Alloc FSM: latch, select candidate, issue, await reply (retry on size 0), reply.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= A_IDLE;
            live_r   <= 1'b0;
            req_r    <= {REQ_W{1'b0}};
            need_r   <= {SZ_W{1'b0}};
            tried_r  <= {NBLK{1'b0}};
            cand_r   <= {BID_W{1'b0}};
            rr_ptr_r <= {BID_W{1'b0}};
            rep_r    <= {XREP_W{1'b0}};
        end else begin
            live_r <= 1'b1;
            case (state_r)
                A_IDLE: begin
                    if (alloc_hs_s) begin
                        req_r   <= pu.req_alloc_data;
                        need_r  <= need_s;
                        tried_r <= {NBLK{1'b0}};
                        state_r <= A_SELECT;
                    end
                end
                A_SELECT: begin
                    if ((need_r == {SZ_W{1'b0}}) || (need_r > SZ_W'(BLOCK_D)) || !cand_any_s) begin
                        rep_r   <= {{BID_W{1'b0}}, req_r[REQ_W-1 -: UDATA_W], {(2*BLOCK_W+1){1'b0}}};
                        state_r <= A_REPLY;
                    end else begin
                        cand_r  <= cand_idx_s;
                        state_r <= A_ISSUE;
                    end
                end
                A_ISSUE: begin
                    if (i_blk_req_alloc_rdy[cand_r]) begin
                        state_r <= A_WAIT;
                    end
                end
                A_WAIT: begin
                    if (rep_vld_s) begin
                        if (rep_sel_s[BASE_LSB-1:0] != {BASE_LSB{1'b0}}) begin
                            rep_r    <= {cand_r, rep_sel_s};
                            rr_ptr_r <= bid_inc(cand_r);
                            state_r  <= A_REPLY;
                        end else begin
                            tried_r[cand_r] <= 1'b1;
                            state_r         <= A_SELECT;
                        end
                    end
                end
                A_REPLY: begin
                    if (pu.rep_alloc_rdy) begin
                        state_r <= A_IDLE;
                    end
                end
                default: state_r <= A_IDLE;
            endcase
        end
    end

    // Block-side alloc strobes decoded from state and the latched candidate.
    always_comb begin
        o_blk_req_alloc_vld = {NBLK{1'b0}};
        o_blk_rep_alloc_rdy = {NBLK{1'b0}};
        if (state_r == A_ISSUE) begin
            o_blk_req_alloc_vld[cand_r] = 1'b1;
        end else if (state_r == A_WAIT) begin
            o_blk_rep_alloc_rdy[cand_r] = 1'b1;
        end else begin
            o_blk_req_alloc_vld = {NBLK{1'b0}};
        end
    end

    assign pu.req_alloc_rdy     = alloc_rdy_s;
    assign pu.rep_alloc_vld     = (state_r == A_REPLY);
    assign pu.rep_alloc_data    = rep_r;
    assign o_blk_req_alloc_data = req_r;
    assign o_rr_ptr             = rr_ptr_r;

    // ---------------- dealloc path ----------------
    logic              dreq_full_r;
    logic              dreq_err_r;
    logic [BID_W-1:0]  dreq_bid_r;
    logic [REP_W-1:0]  dreq_pay_r;
    logic              drep_full_r;
    logic [XREP_W-1:0] drep_data_r;
    logic [BID_W-1:0]  darb_ptr_r;
    logic [NBLK-1:0]   darb_gnt_s;
    logic [BID_W-1:0]  darb_idx_s;
    logic              darb_any_s;
    logic              dreq_err_s;
    logic              drep_space_s;
    logic              dreq_drain_blk_s;
    logic              dreq_drain_err_s;
    logic              dreq_rdy_s;
    logic              dreq_hs_s;
    logic              darb_accept_s;

    assign dreq_err_s       = {1'b0, pu.req_dealloc_data[XREP_W-1 -: BID_W]} >= (BID_W+1)'(NBLK);
    assign drep_space_s     = !drep_full_r || pu.rep_dealloc_rdy;
    assign dreq_drain_blk_s = dreq_full_r && !dreq_err_r && i_blk_req_dealloc_rdy[dreq_bid_r];
    assign dreq_drain_err_s = dreq_full_r && dreq_err_r && drep_space_s;
    assign dreq_rdy_s       = live_r && (!dreq_full_r || dreq_drain_blk_s || dreq_drain_err_s);
    assign dreq_hs_s        = pu.req_dealloc_vld && dreq_rdy_s;
    // An out-of-range error reply takes the output slot ahead of block replies.
    assign darb_accept_s    = live_r && drep_space_s && darb_any_s && !dreq_drain_err_s;

    qpl_rr_arb #(.N(NBLK)) u_dealloc_arb (
        .req (i_blk_rep_dealloc_vld),
        .ptr (darb_ptr_r),
        .gnt (darb_gnt_s),
        .idx (darb_idx_s),
        .any (darb_any_s)
    );

    // One-entry dealloc request register; refills in the cycle it drains.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dreq_full_r <= 1'b0;
            dreq_err_r  <= 1'b0;
            dreq_bid_r  <= {BID_W{1'b0}};
            dreq_pay_r  <= {REP_W{1'b0}};
        end else if (dreq_hs_s) begin
            dreq_full_r <= 1'b1;
            dreq_err_r  <= dreq_err_s;
            dreq_bid_r  <= pu.req_dealloc_data[XREP_W-1 -: BID_W];
            dreq_pay_r  <= pu.req_dealloc_data[REP_W-1:0];
        end else if (dreq_drain_blk_s || dreq_drain_err_s) begin
            dreq_full_r <= 1'b0;
        end
    end

    // One-entry dealloc reply register fed by the error path or the arbiter winner.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drep_full_r <= 1'b0;
            drep_data_r <= {XREP_W{1'b0}};
            darb_ptr_r  <= {BID_W{1'b0}};
        end else if (dreq_drain_err_s) begin
            drep_full_r <= 1'b1;
            drep_data_r <= {dreq_bid_r, dreq_pay_r[REP_W-1 -: UDATA_W], {UDATA_LSB{1'b0}}};
        end else if (darb_accept_s) begin
            drep_full_r <= 1'b1;
            drep_data_r <= {darb_idx_s, i_blk_rep_dealloc_data[darb_idx_s]};
            darb_ptr_r  <= bid_inc(darb_idx_s);
        end else if (pu.rep_dealloc_rdy) begin
            drep_full_r <= 1'b0;
        end
    end

    // Steer the held request to its target block.
    always_comb begin
        o_blk_req_dealloc_vld = {NBLK{1'b0}};
        if (dreq_full_r && !dreq_err_r) begin
            o_blk_req_dealloc_vld[dreq_bid_r] = 1'b1;
        end else begin
            o_blk_req_dealloc_vld = {NBLK{1'b0}};
        end
    end

    assign o_blk_req_dealloc_data = dreq_pay_r;
    assign o_blk_rep_dealloc_rdy  = darb_gnt_s & {NBLK{darb_accept_s}};
    assign pu.req_dealloc_rdy     = dreq_rdy_s;
    assign pu.rep_dealloc_vld     = drep_full_r;
    assign pu.rep_dealloc_data    = drep_data_r;

endmodule
